// File: rtl/cost_port_arbiter_pkg.sv
// Shared solver package: default widths of the cost-table read port (W/J index,
// Cost data), burst limit and the arbiter state encoding.
package cost_port_arbiter_pkg;

   localparam int NREQ_DEF      = 4;
   localparam int AW_DEF        = 3;   // width of each of W and J on the cost-table port
   localparam int CW_DEF        = 7;   // Cost word width on the cost-table port
   localparam int MAX_BURST_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first asserted request scanning
// ptr, ptr+1, ... mod N, returned one-hot together with an any-request flag.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          any_o
);

   logic [PW-1:0] idx;

   // NOTE: every output and temporary is given a default before the scan so no
   // path through the loop leaves a value unassigned, which would infer a latch.
   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr_i) + i) % N);
         if (!any_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cost_port_arbiter.sv
// Round-robin arbiter sharing the cost-table read port between NREQ search
// engines: locked bursts, registered W/J, Cost returned with a one-hot tag.
module cost_port_arbiter
   import cost_port_arbiter_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int AW        = AW_DEF,
   parameter int CW        = CW_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    last,
   input  logic [NREQ*AW-1:0] w_in,
   input  logic [NREQ*AW-1:0] j_in,
   output logic [NREQ-1:0]    gnt,
   output logic [AW-1:0]      W,
   output logic [AW-1:0]      J,
   input  logic [CW-1:0]      Cost,
   output logic [NREQ-1:0]    rvalid,
   output logic [CW-1:0]      rdata,
   output logic               ovf
);

   localparam int PW   = $clog2(NREQ);
   localparam int CNTW = $clog2(MAX_BURST + 1);

   arb_state_e      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, pick_idx, owner_nxt;
   logic [NREQ-1:0] gnt_q, gnt_d, pick_gnt, tag_q, rvalid_q;
   logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            ovf_q, ovf_d;
   logic            pick_any, accept, owner_last, hit_max, rel_burst;
   logic [AW-1:0]   w_q, j_q;
   logic [CW-1:0]   rdata_q;
   logic [AW-1:0]   w_arr [NREQ];
   logic [AW-1:0]   j_arr [NREQ];

   for (genvar k = 0; k < NREQ; k++) begin : g_unpack
      assign w_arr[k] = w_in[k*AW +: AW];
      assign j_arr[k] = j_in[k*AW +: AW];
   end

   rr_pick #(
      .N  (NREQ),
      .PW (PW)
   ) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .any_o (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_gnt[k]) pick_idx = PW'(k);
      end
   end

   // Only the owner's req/last matter while locked; everyone else is ignored.
   assign accept     = (state_q == LOCK) && req[owner_q];
   assign owner_last = last[owner_q];
   assign cnt_inc    = cnt_q + 1'b1;
   assign hit_max    = (cnt_inc == CNTW'(MAX_BURST));
   assign rel_burst  = accept && (owner_last || hit_max);
   assign owner_nxt  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      ovf_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_any) begin
               state_d = LOCK;
               gnt_d   = pick_gnt;
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         LOCK: begin
            if (accept) cnt_d = cnt_inc;
            if (rel_burst) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = owner_nxt;
               ovf_d   = hit_max && !owner_last;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         gnt_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         w_q      <= '0;
         j_q      <= '0;
         tag_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         if (accept) begin
            w_q <= w_arr[owner_q];
            j_q <= j_arr[owner_q];
         end
         // Tag travels with W/J, then strobes rvalid as the sampled Cost leaves.
         tag_q    <= accept ? gnt_q : '0;
         rvalid_q <= tag_q;
         if (|tag_q) rdata_q <= Cost;
      end
   end

   assign gnt    = gnt_q;
   assign W      = w_q;
   assign J      = j_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_cost_port_arbiter.sv
// Self-checking bench for cost_port_arbiter: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cost_port_arbiter;

   localparam int NREQ      = 4;
   localparam int AW        = 3;
   localparam int CW        = 7;
   localparam int MAX_BURST = 8;

   logic               CLK;
   logic               RST;
   logic [NREQ-1:0]    req, last;
   logic [NREQ*AW-1:0] w_in, j_in;
   logic [NREQ-1:0]    gnt, rvalid;
   logic [AW-1:0]      W, J;
   logic [CW-1:0]      Cost, rdata;
   logic               ovf;

   cost_port_arbiter #(
      .NREQ(NREQ), .AW(AW), .CW(CW), .MAX_BURST(MAX_BURST)
   ) dut (
      .CLK(CLK), .RST(RST), .req(req), .last(last), .w_in(w_in), .j_in(j_in),
      .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rvalid(rvalid), .rdata(rdata), .ovf(ovf)
   );

   // Cost table: entry (W,J) holds W*10+J.
   assign Cost = CW'(int'(W) * 10 + int'(J));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int due; int owner; int cost; } resp_t;
   resp_t pend[$];
   int    m_cyc = 0, m_owner = 0, m_ptr = 0, m_beats = 0;
   bit    m_busy = 0;
   logic [NREQ-1:0] e_gnt, e_rvalid;
   logic [AW-1:0]   e_w, e_j;
   logic [CW-1:0]   e_rdata;
   logic            e_ovf;

   always @(posedge CLK) begin
      bit found;
      m_cyc++;
      if (RST) begin
         m_busy = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
         pend.delete();
         e_gnt = '0; e_rvalid = '0; e_w = '0; e_j = '0; e_rdata = '0; e_ovf = 1'b0;
      end else begin
         e_ovf = 1'b0;
         if (m_busy) begin
            if (req[m_owner]) begin
               e_w = w_in[m_owner*AW +: AW];
               e_j = j_in[m_owner*AW +: AW];
               m_beats++;
               pend.push_back('{due: m_cyc + 1, owner: m_owner, cost: int'(e_w) * 10 + int'(e_j)});
               if (last[m_owner] || m_beats == MAX_BURST) begin
                  e_ovf  = !last[m_owner];
                  m_busy = 0;
                  m_ptr  = (m_owner + 1) % NREQ;
               end
            end
         end else begin
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
               if (!found && req[(m_ptr + i) % NREQ]) begin
                  found = 1; m_busy = 1; m_owner = (m_ptr + i) % NREQ; m_beats = 0;
               end
            end
         end
         e_gnt    = m_busy ? (NREQ'(1) << m_owner) : '0;
         e_rvalid = '0;
         if (pend.size() > 0 && pend[0].due == m_cyc) begin
            e_rvalid = NREQ'(1) << pend[0].owner;
            e_rdata  = CW'(pend[0].cost);
            void'(pend.pop_front());
         end
      end
   end

   // ---------------- compare process ----------------
   bit              cmp_en = 0;
   int              log_idx = 0;
   int              rd_log[$];
   int              grant_log[$];
   int              ovf_cnt = 0;
   logic [NREQ-1:0] prev_gnt = '0;

   always @(negedge CLK) begin
      if (cmp_en) begin
         check("gnt", gnt, e_gnt);
         check("W", W, e_w);
         check("J", J, e_j);
         check("rvalid", rvalid, e_rvalid);
         check("rdata", rdata, e_rdata);
         check("ovf", ovf, e_ovf);
         if (gnt != '0 && prev_gnt == '0)
            for (int k = 0; k < NREQ; k++) if (gnt[k]) grant_log.push_back(k);
         prev_gnt = gnt;
         if (rvalid[log_idx]) rd_log.push_back(int'(rdata));
         if (ovf) ovf_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic set_wj(input int k, input int wv, input int jv);
      w_in[k*AW +: AW] = AW'(wv);
      j_in[k*AW +: AW] = AW'(jv);
   endtask

   task automatic do_reset();
      RST = 1'b1; req = '0; last = '0;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      int              bcnt [NREQ];
      int              done;
      int              exp2 [4] = '{0, 2, 0, 2};
      logic [NREQ-1:0] g;

      RST = 1'b1; req = '0; last = '0; w_in = '0; j_in = '0;
      @(posedge CLK); #1 cmp_en = 1;
      tick();
      RST = 1'b0;
      check("rst_gnt", gnt, 0);
      check("rst_W", W, 0);
      check("rst_rvalid", rvalid, 0);

      // Single requester 1, W=0..7, J=3.
      log_idx = 1; rd_log.delete();
      req = 4'b0010; set_wj(1, 0, 3);
      tick();
      check("t1_gnt_rise", gnt, 4'b0010);
      for (int i = 0; i < 8; i++) begin
         set_wj(1, i, 3);
         last[1] = (i == 7);
         tick();
      end
      req = '0; last = '0;
      check("t1_gnt_drop", gnt, 0);
      check("t1_ovf", ovf, 0);
      repeat (3) tick();
      check("t1_nresp", rd_log.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < rd_log.size()) check("t1_rdata", rd_log[i], 10 * i + 3);

      // Contention between requesters 0 and 2.
      do_reset();
      grant_log.delete();
      for (int k = 0; k < NREQ; k++) bcnt[k] = 0;
      done = 0;
      req = 4'b0101;
      for (int c = 0; c < 80 && done < 4; c++) begin
         g = gnt;
         for (int k = 0; k < NREQ; k++) last[k] = g[k] && (bcnt[k] == 7);
         w_in = NREQ*AW'($urandom); j_in = NREQ*AW'($urandom);
         tick();
         for (int k = 0; k < NREQ; k++)
            if (g[k] && req[k]) begin
               if (bcnt[k] == 7) begin bcnt[k] = 0; done++; end
               else bcnt[k]++;
            end
      end
      req = '0; last = '0;
      check("t2_bursts", done, 4);
      check("t2_ngrants", grant_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < grant_log.size()) check("t2_order", grant_log[i], exp2[i]);
      repeat (3) tick();

      // Wait states on requester 3.
      do_reset();
      log_idx = 3; rd_log.delete();
      req = 4'b1000; set_wj(3, 0, 5);
      tick();
      for (int i = 0; i < 4; i++) begin set_wj(3, i, 5); tick(); end
      req = '0; set_wj(3, 7, 7);
      repeat (3) tick();
      check("t3_gnt_held", gnt, 4'b1000);
      check("t3_W_frozen", W, 3);
      check("t3_J_frozen", J, 5);
      req = 4'b1000;
      for (int i = 4; i < 8; i++) begin set_wj(3, i, 5); last[3] = (i == 7); tick(); end
      req = '0; last = '0;
      repeat (3) tick();
      check("t3_nresp", rd_log.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < rd_log.size()) check("t3_rdata", rd_log[i], 10 * i + 5);

      // Overflow: requester 1 never asserts last, requester 2 waiting.
      do_reset();
      grant_log.delete(); ovf_cnt = 0;
      req = 4'b0110; last = '0;
      for (int i = 1; i <= 12; i++) begin
         w_in = NREQ*AW'($urandom); j_in = NREQ*AW'($urandom);
         tick();
         if (i == 9)  check("t4_ovf_pulse", ovf, 1);
         if (i == 10) check("t4_next_gnt", gnt, 4'b0100);
      end
      req = '0;
      check("t4_ovf_count", ovf_cnt, 1);
      check("t4_ngrants", grant_log.size(), 2);
      if (grant_log.size() == 2) check("t4_second", grant_log[1], 2);

      // Reset mid-burst after 4 beats.
      do_reset();
      req = 4'b1000;
      tick();
      for (int i = 0; i < 4; i++) begin set_wj(3, i + 1, 2); tick(); end
      RST = 1'b1; req = 4'b1010;
      tick();
      check("t5_gnt", gnt, 0);
      check("t5_W", W, 0);
      check("t5_J", J, 0);
      check("t5_rvalid", rvalid, 0);
      check("t5_rdata", rdata, 0);
      check("t5_ovf", ovf, 0);
      RST = 1'b0;
      tick();
      check("t5_first_gnt", gnt, 4'b0010);
      check("t5_no_stale", rvalid, 0);
      tick();
      check("t5_no_stale2", rvalid, 0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         RST  = ($urandom_range(0, 99) == 0);
         req  = NREQ'($urandom);
         last = NREQ'($urandom) & NREQ'($urandom);
         w_in = NREQ*AW'($urandom);
         j_in = NREQ*AW'($urandom);
         tick();
      end
      RST = 1'b0; req = '0; last = '0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
